mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/scpu_mem_pkg.sv | 21 ++
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/scpu_mem_pkg.sv
// Shared definitions for the scalar-CPU memory path: RAM geometry, request width
// and the mem_ctrl state encoding.
package scpu_mem_pkg;

  localparam int MEM_AW = 11;
  localparam int MEM_DW = 8;
  localparam int REQ_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    WR_HI = 2'd3
  } mem_state_e;

  // Second-byte address of a word access; wraps 0x7FF -> 0x000.
  function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a);
    return a + {{(MEM_AW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte/word request front-end for a single-port 2Kx8 bypass-read RAM.
// Define MEM_CTRL_WORD_EN to build 16-bit (little-endian) accesses; otherwise every access is a byte.
module mem_ctrl
  import scpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_word,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [REQ_DW-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [REQ_DW-1:0] rsp_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic              ram_wre,
  output logic [MEM_AW-1:0] ram_ad,
  output logic [MEM_DW-1:0] ram_din,
  input  logic [MEM_DW-1:0] ram_dout
);

  mem_state_e        r_state;
  mem_state_e        w_state_nxt;
  logic              r_rsp_valid;
  logic [REQ_DW-1:0] r_rdata;
  logic [REQ_DW-1:0] w_rdata_nxt;
  logic              w_accept;
  logic              w_done;
  logic              w_ce;
  logic              w_wre;

`ifdef MEM_CTRL_WORD_EN
  logic              r_word;
  logic [MEM_AW-1:0] r_addr_hi;
  logic [MEM_DW-1:0] r_wdata_hi;
  logic [MEM_DW-1:0] r_rdata_lo;
`else
  logic              w_unused_word;
  assign w_unused_word = &{1'b0, req_word, req_wdata[REQ_DW-1:MEM_DW]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_rdata_nxt = r_rdata;
    w_ce        = 1'b0;
    w_wre       = 1'b0;
    ram_ad      = req_addr;
    ram_din     = req_wdata[MEM_DW-1:0];
    case (r_state)
      IDLE: begin
        // RAM sees the request directly so it captures on the accept edge.
        if (req_valid) begin
          w_accept = 1'b1;
          w_ce     = 1'b1;
          w_wre    = req_we;
          if (!req_we) begin
            w_state_nxt = RD_LO;
          end
`ifdef MEM_CTRL_WORD_EN
          else if (req_word) begin
            w_state_nxt = WR_HI;
          end
`endif
          else begin
            w_done = 1'b1;
          end
        end
      end
      RD_LO: begin
`ifdef MEM_CTRL_WORD_EN
        if (r_word) begin
          w_ce        = 1'b1;
          ram_ad      = r_addr_hi;
          w_state_nxt = RD_HI;
        end else begin
          w_done      = 1'b1;
          w_rdata_nxt = {{(REQ_DW-MEM_DW){1'b0}}, ram_dout};
          w_state_nxt = IDLE;
        end
`else
        w_done      = 1'b1;
        w_rdata_nxt = {{(REQ_DW-MEM_DW){1'b0}}, ram_dout};
        w_state_nxt = IDLE;
`endif
      end
`ifdef MEM_CTRL_WORD_EN
      RD_HI: begin
        // Response word is assembled in one step so rsp_rdata only moves on completion.
        w_done      = 1'b1;
        w_rdata_nxt = {ram_dout, r_rdata_lo};
        w_state_nxt = IDLE;
      end
      WR_HI: begin
        w_ce        = 1'b1;
        w_wre       = 1'b1;
        ram_ad      = r_addr_hi;
        ram_din     = r_wdata_hi;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Gating with reset is what aborts a pending high-byte write.
  assign ram_ce    = w_ce & ~reset;
  assign ram_wre   = w_wre & ~reset;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_done;
      r_rdata     <= w_rdata_nxt;
    end
  end

`ifdef MEM_CTRL_WORD_EN
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word     <= req_word;
      r_addr_hi  <= next_addr(req_addr);
      r_wdata_hi <= req_wdata[REQ_DW-1:MEM_DW];
    end
    if (r_state == RD_LO) begin
      r_rdata_lo <= ram_dout;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 2Kx8 bypass-read RAM.
// Expectations follow the MEM_CTRL_WORD_EN setting used for the build.
module tb_mem_ctrl;
  import scpu_mem_pkg::*;

`ifdef MEM_CTRL_WORD_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_word;
  logic [MEM_AW-1:0] req_addr;
  logic [REQ_DW-1:0] req_wdata;
  logic              rsp_valid;
  logic [REQ_DW-1:0] rsp_rdata;
  logic              ram_ce;
  logic              ram_oce;
  logic              ram_reset;
  logic              ram_wre;
  logic [MEM_AW-1:0] ram_ad;
  logic [MEM_DW-1:0] ram_din;
  logic [MEM_DW-1:0] ram_dout;

  logic [7:0] mem [2048];
  logic [7:0] b2b_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  int n_assert = 0;
  int n_fail   = 0;

  mem_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_word (req_word),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .ram_ce   (ram_ce),
    .ram_oce  (ram_oce),
    .ram_reset(ram_reset),
    .ram_wre  (ram_wre),
    .ram_ad   (ram_ad),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address captured on the edge, read data valid the following cycle.
  always @(posedge clk) begin
    if (ram_reset) begin
      ram_dout <= 8'h00;
    end else if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no end of test, required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request in the current cycle, steps over the accept edge, then scrambles inputs.
  task automatic issue(input logic we, input logic word, input logic [10:0] addr,
                       input logic [15:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_word  = word;
    req_addr  = addr;
    req_wdata = wd;
    chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wd;
  endtask

  // Called in the cycle after accept; checks latency, data and single-cycle pulse.
  task automatic expect_rsp(input string tag, input int lat, input logic [15:0] data);
    int k;
    k = 1;
    while (rsp_valid !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    if (rsp_valid !== 1'b1) k = 99;
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, data});
    step();
    chk({tag, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int pulses;
    int acc;
    logic acc_now;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_word  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    step();
    step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("rst_ram_wre", {31'd0, ram_wre}, 32'd0);
    chk("rst_ram_reset", {31'd0, ram_reset}, 32'd1);
    reset = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("ram_oce", {31'd0, ram_oce}, 32'd1);
    chk("ram_reset_low", {31'd0, ram_reset}, 32'd0);
    chk("idle_ce", {31'd0, ram_ce}, 32'd0);

    // Byte write then byte read.
    issue(1'b1, 1'b0, 11'h010, 16'h005A);
    expect_rsp("bwr_010", 1, 16'h0000);
    chk("mem_010", {24'd0, mem[11'h010]}, 32'h5A);
    issue(1'b0, 1'b0, 11'h010, 16'h0000);
    expect_rsp("brd_010", 2, 16'h005A);

    // Word write/read at 0x020 (byte behaviour when word support is not built).
    issue(1'b1, 1'b1, 11'h020, 16'hBEEF);
    expect_rsp("wwr_020", WEN ? 2 : 1, 16'h005A);
    chk("mem_020", {24'd0, mem[11'h020]}, 32'hEF);
    if (WEN) chk("mem_021", {24'd0, mem[11'h021]}, 32'hBE);
    issue(1'b0, 1'b1, 11'h020, 16'h0000);
    expect_rsp("wrd_020", WEN ? 3 : 2, WEN ? 16'hBEEF : 16'h00EF);

    // Word access wrapping at the top of the address space.
    issue(1'b1, 1'b1, 11'h7FF, 16'h1234);
    expect_rsp("wwr_7ff", WEN ? 2 : 1, WEN ? 16'hBEEF : 16'h00EF);
    chk("mem_7ff", {24'd0, mem[11'h7FF]}, 32'h34);
    if (WEN) chk("mem_000", {24'd0, mem[11'h000]}, 32'h12);
    issue(1'b0, 1'b1, 11'h7FF, 16'h0000);
    expect_rsp("wrd_7ff", WEN ? 3 : 2, WEN ? 16'h1234 : 16'h0034);

    // Back-to-back byte reads with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 11'h100 + 11'(i), {8'h00, b2b_exp[i]});
      step();
    end
    pulses    = 0;
    acc       = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_word  = 1'b0;
    req_addr  = 11'h100;
    for (int c = 0; c < 20; c++) begin
      acc_now = req_valid & req_ready;
      if (rsp_valid === 1'b1) begin
        if (pulses < 4) chk("b2b_data", {16'd0, rsp_rdata}, {24'd0, b2b_exp[pulses]});
        pulses++;
      end
      if (acc_now && acc > 0) chk("b2b_overlap", {31'd0, rsp_valid}, 32'd1);
      step();
      if (acc_now) begin
        acc++;
        if (acc == 4) req_valid = 1'b0;
        else          req_addr  = 11'h100 + 11'(acc);
      end
    end
    chk("b2b_accepts", acc, 4);
    chk("b2b_pulses", pulses, 4);

    // Reset during RD_LO of a byte read aborts without a response.
    issue(1'b0, 1'b0, 11'h010, 16'h0000);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid === 1'b1) pulses++;
      step();
    end
    chk("rdlo_abort_pulses", pulses, 0);
    chk("rdlo_abort_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rdlo_abort_ready", {31'd0, req_ready}, 32'd1);

`ifdef MEM_CTRL_WORD_EN
    // Reset in WR_HI leaves only the low byte written.
    issue(1'b1, 1'b0, 11'h041, 16'h0077);
    step();
    issue(1'b1, 1'b1, 11'h040, 16'hAAAA);
    chk("wrhi_busy", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid === 1'b1) pulses++;
      step();
    end
    chk("wrhi_abort_pulses", pulses, 0);
    chk("wrhi_abort_ready", {31'd0, req_ready}, 32'd1);
    chk("wrhi_mem_040", {24'd0, mem[11'h040]}, 32'hAA);
    chk("wrhi_mem_041", {24'd0, mem[11'h041]}, 32'h77);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
